hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised successor to the pipeline's combinational load-use stall logic. Keeps a per-register countdown scoreboard of in-flight results with variable latency (loads, multi-cycle ALU ops), and stalls the ID stage until every used source can be forwarded. Also stalls on a busy multi-cycle unit. Squashes the issuing instruction on flush. Sits between the ID stage and the ID/EX pipeline register; drives PC/IF-ID hold and the ID/EX bubble.

Parameters:
NUM_REGS, 32, architectural register count; register 0 is hardwired zero.
REG_AW, 5, register address width; must satisfy 2**REG_AW >= NUM_REGS.
NUM_SRC, 2, source operands checked per instruction (3 for fused/FP formats).
LAT_W, 3, latency counter width; maximum latency is 2**LAT_W-1.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a valid instruction
id_rs  in  NUM_SRC*REG_AW  packed source addresses; src i at [i*REG_AW +: REG_AW]
id_rs_used  in  NUM_SRC  per-source "operand actually read" flag
id_rd  in  REG_AW  destination address
id_we  in  1  instruction writes id_rd
id_lat  in  LAT_W  cycles after issue before the result is forwardable; 0 = forwardable next cycle (plain ALU)
id_needs_mc  in  1  instruction needs the multi-cycle unit
mc_busy  in  1  multi-cycle unit cannot accept
flush  in  1  branch/jump redirect from EX; ID contents are wrong-path
stall  out  1  hold PC and IF/ID
bubble  out  1  insert NOP into ID/EX
issue  out  1  instruction leaves ID this cycle
pending  out  NUM_REGS  per-register "counter nonzero" vector, for debug

Behaviour:
- Clock and reset: clk, rst_n; asynchronous active-low reset. On reset, all counters are 0, so pending=0. With id_valid=0, stall=bubble=issue=0.
- Counter: cnt[r] is LAT_W bits and holds the remaining cycles until r is forwardable.
  - Each cycle, any nonzero counter decrements by 1.
  - cnt[0] is constant 0.
- Data hazard, per source i:
  - Set when id_valid, id_rs_used[i], id_rs[i]!=0 and cnt[id_rs[i]]!=0.
  - Out-of-range addresses (>=NUM_REGS) never hazard.
- Structural hazard: id_valid & id_needs_mc & mc_busy.
- Outputs:
  - stall = (data hazard | structural hazard) & ~flush. This is combinational from registered state plus ID inputs.
  - bubble = stall | flush.
  - issue = id_valid & ~stall & ~flush.
- Issue write: on issue with id_we and id_rd!=0, cnt[id_rd] <= id_lat.
  - This overrides that register's decrement in the same cycle.
  - WAW on a register with a pending result overwrites with the new latency, since ordering is in-order.
- Flush:
  - Suppresses issue, so no scoreboard write occurs.
  - Does not clear existing counters; all scoreboarded instructions are older than the branch and still commit.
- Self-dependence: an instruction reading its own rd uses the pre-write counter.
- Simultaneous flush and hazard: flush wins, stall=0 and bubble=1.
- Reset mid-operation clears all counters immediately (async).
- All counters free-run, so a stall always resolves within 2**LAT_W-1 cycles unless mc_busy is held.

Optional Feature:
HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles (32-bit) and mc_stall_cycles (32-bit).
  - Both are saturating counters, reset to 0, incremented on each cycle stall=1.
  - mc_stall_cycles counts only cycles where the structural hazard is the cause.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - default REG_AW and LAT_W;
  - LAT_ALU=0, LAT_LOAD=1, LAT_MUL=2 and LAT_DIV=7 constants used by the decoder;
  - a function extracting source i from the packed id_rs.
- Sub-module hazard_lat_counter: one per register (generate loop). It holds a load/decrement/zero-flag counter with inputs load, load_val and outputs busy.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-stream with cnt[5]=3.
  - Response: pending=0 immediately; after release, ID reading x5 gives stall=0.
- Load-use:
  - Stimulus: issue lw x5 (id_lat=1), then add x6,x5,x1 next cycle.
  - Response: stall=1 and bubble=1 for exactly 1 cycle, issue on the following cycle.
- Divide chain:
  - Stimulus: issue div x7 (id_lat=7), then use x7.
  - Response: 7 stall cycles; pending[7] clears on the 7th cycle after issue.
- x0 and unused source:
  - Stimulus: pending x0 write with id_we=1, rd=0; also a source x5 with id_rs_used=0 while cnt[5]=2.
  - Response: no stall in either case; pending[0] stays 0.
- Flush priority:
  - Stimulus: flush=1 with a load-use hazard present and id_we=1 rd=9 lat=3.
  - Response: stall=0, bubble=1, issue=0, cnt[9] unchanged.
- Structural and WAW:
  - Stimulus: mc_busy=1 for 4 cycles with id_needs_mc; then issue lw x3 lat=1 while cnt[3]=5.
  - Response: 4 stall cycles, then cnt[3]=1; with HAZARD_STATS_EN, mc_stall_cycles=4.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, decoder latency classes and packed-source extraction for the hazard scoreboard.
package hazard_pkg;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_LAT_W  = 3;
    localparam int MAX_AW     = 8;
    localparam int MAX_RS_W   = 64;

    localparam logic [DEF_LAT_W-1:0] LAT_ALU  = 3'd0;
    localparam logic [DEF_LAT_W-1:0] LAT_LOAD = 3'd1;
    localparam logic [DEF_LAT_W-1:0] LAT_MUL  = 3'd2;
    localparam logic [DEF_LAT_W-1:0] LAT_DIV  = 3'd7;

    function automatic logic [MAX_AW-1:0] src_at(input logic [MAX_RS_W-1:0] rs, input int i, input int aw);
        logic [MAX_RS_W-1:0] s;
        s = rs >> (i * aw);
        return MAX_AW'(s) & MAX_AW'((1 << aw) - 1);
    endfunction
endpackage

// File: rtl/hazard_lat_counter.sv
// hazard_lat_counter: per-register countdown of cycles until an in-flight result becomes forwardable.
module hazard_lat_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             busy
);
    logic [LAT_W-1:0] cnt_q, cnt_d;

    assign busy  = cnt_q != '0;
    assign cnt_d = load ? load_val : busy ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall/bubble/issue control from a per-register latency scoreboard.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / mc_stall_cycles counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NUM_SRC  = 2,
    parameter int LAT_W    = DEF_LAT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic [LAT_W-1:0]          id_lat,
    input  logic                      id_needs_mc,
    input  logic                      mc_busy,
    input  logic                      flush,
    output logic                      stall,
    output logic                      bubble,
    output logic                      issue,
    output logic [NUM_REGS-1:0]       pending
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               mc_stall_cycles
`endif
);
    logic [NUM_SRC-1:0]  src_haz;
    logic [MAX_RS_W-1:0] rs_ext;
    logic                data_haz, struct_haz;

    assign rs_ext = MAX_RS_W'(id_rs);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] s;
        assign s          = REG_AW'(src_at(rs_ext, i, REG_AW));
        assign src_haz[i] = id_rs_used[i] && s != '0 && int'(s) < NUM_REGS && pending[s];
    end

    assign data_haz   = id_valid && |src_haz;
    assign struct_haz = id_valid && id_needs_mc && mc_busy;
    assign stall      = (data_haz || struct_haz) && !flush;
    assign bubble     = stall || flush;
    assign issue      = id_valid && !stall && !flush;

    // Hazard checks read the pre-write counters, so a load overwriting its own source still waits.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign pending[r] = 1'b0;
        end else begin : g_cnt
            hazard_lat_counter #(.LAT_W(LAT_W)) u_cnt (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (issue && id_we && id_rd == REG_AW'(r)),
                .load_val (id_lat),
                .busy     (pending[r])
            );
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, mc_stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stall_cycles_q    <= '0;
            mc_stall_cycles_q <= '0;
        end else begin
            if (stall && !(&stall_cycles_q))                   stall_cycles_q    <= stall_cycles_q + 1'b1;
            if (stall && struct_haz && !(&mc_stall_cycles_q)) mc_stall_cycles_q <= mc_stall_cycles_q + 1'b1;
        end

    assign stall_cycles    = stall_cycles_q;
    assign mc_stall_cycles = mc_stall_cycles_q;
`else
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors with hand-computed stall/bubble/issue/pending expectations.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_rs = '0;
    logic [1:0]  id_rs_used = '0;
    logic [4:0]  id_rd = '0;
    logic        id_we = 1'b0;
    logic [2:0]  id_lat = '0;
    logic        id_needs_mc = 1'b0;
    logic        mc_busy = 1'b0;
    logic        flush = 1'b0;
    logic        stall, bubble, issue;
    logic [31:0] pending;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, mc_stall_cycles;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_lat      (id_lat),
        .id_needs_mc (id_needs_mc),
        .mc_busy     (mc_busy),
        .flush       (flush),
        .stall       (stall),
        .bubble      (bubble),
        .issue       (issue),
        .pending     (pending)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .mc_stall_cycles (mc_stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] u,
                       input logic [4:0] rd, input logic we, input logic [2:0] lat,
                       input logic mc, input logic mb, input logic fl);
        @(negedge clk);
        id_valid = v; id_rs = {r2, r1}; id_rs_used = u; id_rd = rd; id_we = we; id_lat = lat;
        id_needs_mc = mc; mc_busy = mb; flush = fl;
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk3(input string tag, input logic s, input logic b, input logic i);
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        chk({tag, ".bubble"}, 32'(bubble), 32'(b));
        chk({tag, ".issue"}, 32'(issue), 32'(i));
    endtask

    initial begin
        #1;
        chk("rst.pending", pending, 32'h0);
        chk3("rst", 0, 0, 0);
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // load-use: lw x5 then add x6,x5,x1
        drv(1, 0, 0, 2'b00, 5, 1, LAT_LOAD, 0, 0, 0);
        chk3("lw", 0, 0, 1);
        drv(1, 5, 1, 2'b11, 6, 1, LAT_ALU, 0, 0, 0);
        chk("lu.pending", pending, 32'h0000_0020);
        chk3("lu.stall", 1, 1, 0);
        drv(1, 5, 1, 2'b11, 6, 1, LAT_ALU, 0, 0, 0);
        chk3("lu.go", 0, 0, 1);
        chk("lu.clear", pending, 32'h0);

        // div chain: 7 stall cycles then issue
        drv(1, 0, 0, 2'b00, 7, 1, LAT_DIV, 0, 0, 0);
        chk3("div", 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            drv(1, 7, 0, 2'b01, 8, 0, 0, 0, 0, 0);
            chk($sformatf("div.wait%0d", k), {31'b0, stall}, 32'h1);
            chk($sformatf("div.pend%0d", k), pending, 32'h0000_0080);
        end
        drv(1, 7, 0, 2'b01, 8, 0, 0, 0, 0, 0);
        chk3("div.go", 0, 0, 1);
        chk("div.clear", pending, 32'h0);

        // x0 write ignored, unused source ignored
        drv(1, 0, 0, 2'b00, 0, 1, 3'd3, 0, 0, 0);
        chk3("x0.wr", 0, 0, 1);
        drv(1, 0, 0, 2'b00, 5, 1, LAT_MUL, 0, 0, 0);
        chk("x0.pend", pending, 32'h0);
        drv(1, 5, 5, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("unused.pend", pending, 32'h0000_0020);
        chk3("unused", 0, 0, 1);
        drv(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0);
        chk3("src1.haz", 1, 1, 0);

        // flush wins over hazard and suppresses the write
        drv(1, 0, 0, 2'b00, 4, 1, LAT_LOAD, 0, 0, 0);
        chk3("fl.lw", 0, 0, 1);
        drv(1, 4, 0, 2'b01, 9, 1, 3'd3, 0, 0, 1);
        chk3("fl.haz", 0, 1, 0);
        drv(1, 0, 0, 2'b00, 10, 0, 0, 0, 0, 1);
        chk("fl.pend", pending, 32'h0);
        chk3("fl.nohaz", 0, 1, 0);

        // structural hazard then WAW
        for (int k = 0; k < 4; k++) begin
            drv(1, 0, 0, 2'b00, 11, 1, LAT_ALU, 1, 1, 0);
            chk3($sformatf("mc%0d", k), 1, 1, 0);
        end
        drv(1, 0, 0, 2'b00, 3, 1, 3'd5, 1, 0, 0);
        chk3("mc.go", 0, 0, 1);
`ifdef HAZARD_STATS_EN
        chk("stats.mc", mc_stall_cycles, 32'd4);
        chk("stats.all", stall_cycles, 32'd13);
`endif
        drv(1, 0, 0, 2'b00, 3, 1, LAT_LOAD, 0, 0, 0);
        chk3("waw.lw", 0, 0, 1);
        drv(1, 3, 0, 2'b01, 12, 0, 0, 0, 0, 0);
        chk("waw.pend", pending, 32'h0000_0008);
        chk3("waw.stall", 1, 1, 0);
        drv(1, 3, 0, 2'b01, 12, 0, 0, 0, 0, 0);
        chk3("waw.go", 0, 0, 1);

        // async reset mid-operation
        drv(1, 0, 0, 2'b00, 5, 1, 3'd3, 0, 0, 0);
        idle();
        chk("rst2.before", pending, 32'h0000_0020);
        rst_n = 1'b0;
        #1;
        chk("rst2.async", pending, 32'h0);
        drv(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk3("rst2.use", 0, 0, 1);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
